// File: rtl/dma_fetch_responder_if.sv
// Signal bundle between the descriptor engine, the cache read port and
// video BRAM, as seen by dma_fetch_responder.
interface dma_fetch_responder_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int VADDR_WIDTH = 18,
    parameter int DATA_WIDTH  = 32
);
    logic                   fetch_data;
    logic [ADDR_WIDTH-1:0]  read_from;
    logic [VADDR_WIDTH-1:0] write_to;
    logic [15:0]            length_data;
    logic                   ack_fetch_data;
    logic                   error;
    logic                   busy;

    logic                   mem_req;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic                   mem_gnt;
    logic                   mem_rvalid;
    logic [DATA_WIDTH-1:0]  mem_rdata;

    logic                   videomem_we;
    logic [VADDR_WIDTH-1:0] videomem_addr;
    logic [DATA_WIDTH-1:0]  videomem_wdata;

    // Requester plus cache/BRAM environment
    modport master (
        output fetch_data, read_from, write_to, length_data,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  ack_fetch_data, error, busy,
        input  mem_req, mem_addr,
        input  videomem_we, videomem_addr, videomem_wdata
    );

    modport slave (
        input  fetch_data, read_from, write_to, length_data,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output ack_fetch_data, error, busy,
        output mem_req, mem_addr,
        output videomem_we, videomem_addr, videomem_wdata
    );
endinterface

// File: rtl/dma_fetch_responder.sv
// Memory-side responder for descriptor fetches: copies a short burst of dwords
// from the cache read port into video BRAM, then pulses an acknowledge.
module dma_fetch_responder #(
    parameter int ADDR_WIDTH  = 16,
    parameter int VADDR_WIDTH = 18,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_BURST   = 8
) (
    input logic                  clk,
    input logic                  rst,
    dma_fetch_responder_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_ACK     = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  src;
        logic [VADDR_WIDTH-1:0] dst;
        logic [3:0]             len;
        logic                   bad;
    } req_t;

    logic [2:0]             state, state_nx;
    req_t                   req_q;
    logic [3:0]             issued, received;
    logic                   len_bad, last_gnt, take_rd, accept;
    logic                   we_q;
    logic [VADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;

    assign accept   = (state == S_IDLE) && bus.fetch_data;
    assign len_bad  = (bus.length_data == 16'd0) || (bus.length_data > 16'(MAX_BURST));
    assign last_gnt = bus.mem_gnt && ((issued + 4'd1) == req_q.len);
    // Returns past the requested count, or outside a burst, are dropped.
    assign take_rd  = ((state == S_READ) || (state == S_DRAIN)) &&
                      bus.mem_rvalid && (received != req_q.len);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (bus.fetch_data) state_nx = len_bad ? S_ACK : S_READ;
            S_READ:    if (last_gnt) state_nx = S_DRAIN;
            // received only reaches len on the edge that raises the final
            // write strobe, so this fires once that write cycle has elapsed.
            S_DRAIN:   if (received == req_q.len) state_nx = S_ACK;
            S_ACK:     state_nx = S_RELEASE;
            S_RELEASE: if (!bus.fetch_data) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            req_q    <= '0;
            issued   <= '0;
            received <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state <= state_nx;
            we_q  <= take_rd;
            if (accept) begin
                req_q.src <= bus.read_from;
                req_q.dst <= bus.write_to;
                req_q.len <= bus.length_data[3:0];
                req_q.bad <= len_bad;
                issued    <= '0;
                received  <= '0;
            end
            if ((state == S_READ) && bus.mem_gnt)
                issued <= issued + 4'd1;
            if (take_rd) begin
                waddr_q  <= req_q.dst + VADDR_WIDTH'({received, 2'b00});
                wdata_q  <= bus.mem_rdata;
                received <= received + 4'd1;
            end
        end
    end

    assign bus.mem_req        = (state == S_READ);
    assign bus.mem_addr       = (state == S_READ) ? req_q.src + ADDR_WIDTH'({issued, 2'b00}) : '0;
    assign bus.ack_fetch_data = (state == S_ACK);
    assign bus.error          = (state == S_ACK) && req_q.bad;
    assign bus.busy           = (state == S_READ) || (state == S_DRAIN) || (state == S_ACK);
    assign bus.videomem_we    = we_q;
    assign bus.videomem_addr  = waddr_q;
    assign bus.videomem_wdata = wdata_q;
endmodule

// File: tb/tb_dma_fetch_responder.sv
// Directed bench for dma_fetch_responder: a scripted cache responder plus
// checks on read addresses, BRAM writes and the ack/error handshake.
module tb_dma_fetch_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rc;

    dma_fetch_responder_if bus ();
    dma_fetch_responder dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    bit          gnt_en, gnt_alt;
    int          lat, beat;
    logic [31:0] dbase;
    int          due_q[$];
    logic [31:0] rdat_q[$];
    logic [15:0] rd_q[$];
    logic [17:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          ack_cnt, err_cnt, req_cnt, first_req_cyc, last_wr_cyc, last_ack_cyc;
    logic [15:0] bad_len [3] = '{16'd0, 16'd9, 16'h0108};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: observe DUT outputs mid-cycle, then drive the cache side
    // for the coming edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.videomem_we) begin
            wa_q.push_back(bus.videomem_addr);
            wd_q.push_back(bus.videomem_wdata);
            last_wr_cyc = cyc;
        end
        if (bus.ack_fetch_data) begin
            ack_cnt++;
            last_ack_cyc = cyc;
            if (bus.error) err_cnt++;
        end
        if (bus.mem_req) begin
            req_cnt++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdat_q.pop_front();
        end
        bus.mem_gnt = gnt_en && (!gnt_alt || (cyc % 2) == 1);
        if (bus.mem_req && bus.mem_gnt) begin
            rd_q.push_back(bus.mem_addr);
            due_q.push_back(cyc + lat);
            rdat_q.push_back(dbase + 32'(beat));
            beat++;
        end
    endtask

    task automatic clr();
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        ack_cnt = 0; err_cnt = 0; req_cnt = 0; beat = 0;
        first_req_cyc = -1; last_wr_cyc = -1; last_ack_cyc = -1;
    endtask

    task automatic request(input logic [15:0] src, input logic [17:0] dst,
                           input logic [15:0] len, input logic [31:0] db, output int at);
        clr();
        dbase           = db;
        bus.read_from   = src;
        bus.write_to    = dst;
        bus.length_data = len;
        bus.fetch_data  = 1'b1;
        at              = cyc;
    endtask

    task automatic wait_ack(input string tag, input int budget);
        int n = 0;
        while (ack_cnt == 0 && n < budget) begin tick(); n++; end
        chk({tag, "_ack_seen"}, 64'(ack_cnt != 0), 1);
    endtask

    task automatic release_req();
        bus.fetch_data = 1'b0;
        repeat (3) tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"},    bus.ack_fetch_data, 0);
        chk({tag, "_error"},  bus.error, 0);
        chk({tag, "_busy"},   bus.busy, 0);
        chk({tag, "_req"},    bus.mem_req, 0);
        chk({tag, "_maddr"},  bus.mem_addr, 0);
        chk({tag, "_we"},     bus.videomem_we, 0);
        chk({tag, "_vaddr"},  bus.videomem_addr, 0);
        chk({tag, "_wdata"},  bus.videomem_wdata, 0);
    endtask

    task automatic chk_burst(input string tag, input int n, input logic [15:0] src,
                             input logic [17:0] dst, input logic [31:0] db);
        logic [15:0] ea;
        logic [17:0] ev;
        logic [31:0] ed;
        chk({tag, "_nrd"}, rd_q.size(), n);
        chk({tag, "_nwr"}, wa_q.size(), n);
        chk({tag, "_nack"}, ack_cnt, 1);
        chk({tag, "_nerr"}, err_cnt, 0);
        for (int k = 0; k < n && k < rd_q.size(); k++) begin
            ea = src + 16'(4 * k);
            chk($sformatf("%s_raddr%0d", tag, k), rd_q[k], ea);
        end
        for (int k = 0; k < n && k < wa_q.size(); k++) begin
            ev = dst + 18'(4 * k);
            ed = db + 32'(k);
            chk($sformatf("%s_waddr%0d", tag, k), wa_q[k], ev);
            chk($sformatf("%s_wdata%0d", tag, k), wd_q[k], ed);
        end
    endtask

    initial begin
        bus.fetch_data = 0; bus.read_from = '0; bus.write_to = '0; bus.length_data = '0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
        gnt_en = 1; gnt_alt = 0; lat = 1; dbase = '0;
        clr();

        // Reset values, during and after reset
        #1 rst = 1'b1;
        #1 chk_zero("in_reset");
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        chk_zero("post_reset");

        // Basic length-8 burst, gnt tied high, rvalid one cycle after grant
        request(16'h0100, 18'h00200, 16'd8, 32'hA0, rc);
        tick();
        chk("basic_busy", bus.busy, 1);
        chk("basic_first_req", first_req_cyc, rc + 1);
        wait_ack("basic", 30);
        chk("basic_turnaround", last_ack_cyc - rc, 11);
        chk("basic_error_at_ack", bus.error, 0);
        release_req();
        chk_burst("basic", 8, 16'h0100, 18'h00200, 32'hA0);
        chk("basic_idle_busy", bus.busy, 0);

        // Alternating grants and 4-cycle return latency
        gnt_alt = 1; lat = 4;
        request(16'h0040, 18'h00080, 16'd3, 32'h10, rc);
        wait_ack("stall", 60);
        chk("stall_ack_after_write", last_ack_cyc, last_wr_cyc + 1);
        release_req();
        chk_burst("stall", 3, 16'h0040, 18'h00080, 32'h10);
        gnt_alt = 0; lat = 1;

        // Illegal lengths: immediate ack+error, no traffic
        for (int i = 0; i < 3; i++) begin
            request(16'h1000, 18'h02000, bad_len[i], 32'h0, rc);
            tick();
            chk($sformatf("badlen%0d_ack", i), bus.ack_fetch_data, 1);
            chk($sformatf("badlen%0d_error", i), bus.error, 1);
            release_req();
            chk($sformatf("badlen%0d_nack", i), ack_cnt, 1);
            chk($sformatf("badlen%0d_nerr", i), err_cnt, 1);
            chk($sformatf("badlen%0d_noreq", i), req_cnt, 0);
            chk($sformatf("badlen%0d_nowr", i), wa_q.size(), 0);
        end

        // Address wrap on both ports
        request(16'hFFF8, 18'h3FFF8, 16'd4, 32'h50, rc);
        wait_ack("wrap", 30);
        release_req();
        chk_burst("wrap", 4, 16'hFFF8, 18'h3FFF8, 32'h50);
        if (rd_q.size() == 4 && wa_q.size() == 4) begin
            chk("wrap_raddr2_const", rd_q[2], 16'h0000);
            chk("wrap_raddr3_const", rd_q[3], 16'h0004);
            chk("wrap_waddr1_const", wa_q[1], 18'h3FFFC);
            chk("wrap_waddr2_const", wa_q[2], 18'h00000);
        end

        // Request held high after ack must not be re-served
        request(16'h0300, 18'h00400, 16'd2, 32'h60, rc);
        wait_ack("held", 30);
        repeat (10) tick();
        chk_burst("held", 2, 16'h0300, 18'h00400, 32'h60);
        chk("held_busy", bus.busy, 0);
        bus.fetch_data = 1'b0;
        tick(); tick();
        request(16'h0500, 18'h00600, 16'd1, 32'h70, rc);
        wait_ack("held2", 30);
        release_req();
        chk_burst("held2", 1, 16'h0500, 18'h00600, 32'h70);

        // Reset in the middle of a 5-word burst
        request(16'h0700, 18'h00800, 16'd5, 32'h80, rc);
        for (int n = 0; n < 20 && wa_q.size() < 2; n++) tick();
        chk("rstmid_two_written", wa_q.size(), 2);
        rst = 1'b1;
        bus.fetch_data = 1'b0;
        #1 chk_zero("rst_mid");
        tick(); tick();
        rst = 1'b0;
        due_q.delete(); rdat_q.delete();
        clr();
        for (int k = 1; k <= 3; k++) begin
            due_q.push_back(cyc + k);
            rdat_q.push_back(32'hDEAD0000 + 32'(k));
        end
        repeat (5) tick();
        chk("stray_nowr", wa_q.size(), 0);
        chk("stray_noreq", req_cnt, 0);
        chk("stray_noack", ack_cnt, 0);
        chk("stray_busy", bus.busy, 0);
        request(16'h0900, 18'h00A00, 16'd2, 32'h90, rc);
        wait_ack("after_rst", 30);
        release_req();
        chk_burst("after_rst", 2, 16'h0900, 18'h00A00, 32'h90);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
